// File: rtl/reg_writeback_queue.sv
// Pending register-writeback FIFO with two forwarding lookup ports.
// Ports: wb_* push side, drain_en/rf_* register file side, lk_* lookups, count/full/empty status.
module reg_writeback_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              drain_en,
   output logic              rf_write,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [DATA_W-1:0] rf_data,
   input  logic [ADDR_W-1:0] lk_addr1,
   input  logic [ADDR_W-1:0] lk_addr2,
   output logic              lk_hit1,
   output logic              lk_hit2,
   output logic [DATA_W-1:0] lk_data1,
   output logic [DATA_W-1:0] lk_data2,
   output logic [CW-1:0]     count,
   output logic              full,
   output logic              empty
);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic push, pop;

   assign full     = (cnt_q == CW'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign count    = cnt_q;
   assign wb_ready = !full;

   // Push is refused whenever full, even if the head pops this cycle.
   assign push = wb_valid && !full;
   assign pop  = rf_write;

   assign rf_write = drain_en && !empty;
   assign rf_addr  = rf_write ? addr_q[rd_ptr_q] : '0;
   assign rf_data  = rf_write ? data_q[rd_ptr_q] : '0;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage is not reset; validity comes from the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr_q] <= wb_addr;
         data_q[wr_ptr_q] <= wb_data;
      end
   end

   // Walk entries oldest to youngest so the last match wins.
   always_comb begin : lookup_p
      logic [PW-1:0] idx;
      idx      = '0;
      lk_hit1  = 1'b0;
      lk_hit2  = 1'b0;
      lk_data1 = '0;
      lk_data2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PW'(i);
         if (CW'(i) < cnt_q) begin
            if (addr_q[idx] == lk_addr1) begin
               lk_hit1  = 1'b1;
               lk_data1 = data_q[idx];
            end
            if (addr_q[idx] == lk_addr2) begin
               lk_hit2  = 1'b1;
               lk_data2 = data_q[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed self-checking bench for reg_writeback_queue.
// Steps cover reset, single write, fill/stall, forwarding, push+pop, reset mid-op, full-with-pop.
module tb_reg_writeback_queue;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wb_valid;
   logic       wb_ready;
   logic [3:0] wb_addr;
   logic [7:0] wb_data;
   logic       drain_en;
   logic       rf_write;
   logic [3:0] rf_addr;
   logic [7:0] rf_data;
   logic [3:0] lk_addr1, lk_addr2;
   logic       lk_hit1, lk_hit2;
   logic [7:0] lk_data1, lk_data2;
   logic [2:0] count;
   logic       full, empty;

   int tests = 0;
   int fails = 0;

   reg_writeback_queue #(.DEPTH(4), .ADDR_W(4), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_addr(wb_addr), .wb_data(wb_data),
      .drain_en(drain_en),
      .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
      .lk_addr1(lk_addr1), .lk_addr2(lk_addr2),
      .lk_hit1(lk_hit1), .lk_hit2(lk_hit2),
      .lk_data1(lk_data1), .lk_data2(lk_data2),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [3:0] a, input logic [7:0] d);
      wb_valid = 1'b1;
      wb_addr  = a;
      wb_data  = d;
      step();
      wb_valid = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      wb_valid = 1'b0;
      wb_addr  = '0;
      wb_data  = '0;
      drain_en = 1'b0;
      lk_addr1 = '0;
      lk_addr2 = '0;
      #3;
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_ready", 32'(wb_ready), 1);
      chk("rst_rfw", 32'(rf_write), 0);
      chk("rst_hit1", 32'(lk_hit1), 0);
      chk("rst_hit2", 32'(lk_hit2), 0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // single write
      drain_en = 1'b1;
      push_one(4'd3, 8'h5A);
      chk("sw_rfw", 32'(rf_write), 1);
      chk("sw_addr", 32'(rf_addr), 3);
      chk("sw_data", 32'(rf_data), 32'h5A);
      chk("sw_cnt", 32'(count), 1);
      step();
      chk("sw_empty", 32'(empty), 1);
      chk("sw_rfw0", 32'(rf_write), 0);
      chk("sw_addr0", 32'(rf_addr), 0);
      chk("sw_data0", 32'(rf_data), 0);

      // fill and stall
      drain_en = 1'b0;
      push_one(4'd1, 8'hA1);
      push_one(4'd2, 8'hA2);
      push_one(4'd3, 8'hA3);
      chk("fs_rfw_hold", 32'(rf_write), 0);
      push_one(4'd4, 8'hA4);
      chk("fs_full", 32'(full), 1);
      chk("fs_ready", 32'(wb_ready), 0);
      chk("fs_cnt", 32'(count), 4);
      push_one(4'hF, 8'hEE);
      chk("fs_cnt5", 32'(count), 4);
      lk_addr1 = 4'hF;
      #1;
      chk("fs_refused", 32'(lk_hit1), 0);
      drain_en = 1'b1;
      #1;
      chk("fs_d1a", 32'(rf_addr), 1);
      chk("fs_d1d", 32'(rf_data), 32'hA1);
      step();
      chk("fs_d2a", 32'(rf_addr), 2);
      chk("fs_d2d", 32'(rf_data), 32'hA2);
      step();
      chk("fs_d3a", 32'(rf_addr), 3);
      chk("fs_d3d", 32'(rf_data), 32'hA3);
      step();
      chk("fs_d4a", 32'(rf_addr), 4);
      chk("fs_d4d", 32'(rf_data), 32'hA4);
      step();
      chk("fs_empty", 32'(empty), 1);

      // forwarding priority
      drain_en = 1'b0;
      lk_addr1 = 4'd2;
      lk_addr2 = 4'd7;
      wb_valid = 1'b1;
      wb_addr  = 4'd2;
      wb_data  = 8'h11;
      #1;
      chk("fw_nosame", 32'(lk_hit1), 0);
      step();
      wb_valid = 1'b0;
      push_one(4'd2, 8'h22);
      chk("fw_hit1", 32'(lk_hit1), 1);
      chk("fw_dat1", 32'(lk_data1), 32'h22);
      chk("fw_hit2", 32'(lk_hit2), 0);
      chk("fw_dat2", 32'(lk_data2), 0);
      chk("fw_cnt", 32'(count), 2);

      // simultaneous push and pop, wraps write pointer
      drain_en = 1'b1;
      wb_valid = 1'b1;
      wb_addr  = 4'd5;
      wb_data  = 8'h33;
      #1;
      chk("pp_h0", 32'(rf_data), 32'h11);
      chk("fw_head_hit", 32'(lk_hit1), 1);
      step();
      chk("pp_cnt1", 32'(count), 2);
      chk("pp_h1", 32'(rf_data), 32'h22);
      wb_addr = 4'd6;
      wb_data = 8'h44;
      step();
      wb_valid = 1'b0;
      chk("pp_cnt2", 32'(count), 2);
      chk("pp_h2", 32'(rf_data), 32'h33);
      step();
      chk("pp_h3a", 32'(rf_addr), 6);
      chk("pp_h3", 32'(rf_data), 32'h44);
      chk("pp_cnt3", 32'(count), 1);
      step();
      chk("pp_empty", 32'(empty), 1);

      // reset mid-operation
      drain_en = 1'b0;
      push_one(4'd8, 8'h81);
      push_one(4'd9, 8'h91);
      push_one(4'hA, 8'hA1);
      chk("rm_cnt", 32'(count), 3);
      lk_addr1 = 4'd8;
      drain_en = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rm_empty", 32'(empty), 1);
      chk("rm_rfw", 32'(rf_write), 0);
      chk("rm_cnt0", 32'(count), 0);
      chk("rm_ready", 32'(wb_ready), 1);
      chk("rm_hit", 32'(lk_hit1), 0);
      step();
      rst_n = 1'b1;
      step();
      chk("rm_stale1", 32'(rf_write), 0);
      step();
      chk("rm_stale2", 32'(rf_write), 0);
      chk("rm_empty2", 32'(empty), 1);

      // full with pop: push refused
      drain_en = 1'b0;
      push_one(4'd1, 8'hC1);
      push_one(4'd2, 8'hC2);
      push_one(4'd3, 8'hC3);
      push_one(4'd4, 8'hC4);
      chk("fp_full", 32'(full), 1);
      drain_en = 1'b1;
      wb_valid = 1'b1;
      wb_addr  = 4'hE;
      wb_data  = 8'hEE;
      #1;
      chk("fp_h0", 32'(rf_data), 32'hC1);
      step();
      wb_valid = 1'b0;
      chk("fp_cnt3", 32'(count), 3);
      lk_addr2 = 4'hE;
      #1;
      chk("fp_nohit", 32'(lk_hit2), 0);
      chk("fp_h1", 32'(rf_data), 32'hC2);
      step();
      chk("fp_h2", 32'(rf_data), 32'hC3);
      step();
      chk("fp_h3", 32'(rf_data), 32'hC4);
      step();
      chk("fp_empty", 32'(empty), 1);
      chk("fp_rfd0", 32'(rf_data), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
